if_stream_feeder: RTL and testbench
===================================

Name: if_stream_feeder

Overview:
Writer-side front end for the PE's input-feature (IF) FIFO. It accepts a serial stream of IF elements over a valid/ready handshake. Each element is tagged with start-of-row and end-of-row flags, and PAR_WRITE tagged elements are packed into one FIFO write word, which is pushed with IF_wen while honouring IF_full. A frame is row_count rows of row_len elements, launched by a start pulse.

Parameters:
DATA_WIDTH, 8, IF element width; equals the PE's IF scratch width.
PAR_WRITE, 2, tagged elements per FIFO write word; must match the IF FIFO write parallelism.
LEN_BITS, 8, width of the row_len and row_count inputs.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
start  in  1  one-cycle frame launch; sampled only in IDLE.
row_len  in  LEN_BITS  elements per row; latched on an accepted start.
row_count  in  LEN_BITS  rows per frame; latched on an accepted start.
s_valid  in  1  upstream element valid.
s_data  in  DATA_WIDTH  upstream element.
s_ready  out  1  element accepted when s_valid && s_ready.
IF_wen  out  1  FIFO write strobe.
IF_din  out  PAR_WRITE*(DATA_WIDTH+2)  packed FIFO write word.
IF_full  in  1  FIFO cannot take a word this cycle.
busy  out  1  high from accepted start until frame drained.
done  out  1  one-cycle pulse when the frame is fully written.
pad_err  out  1  one-cycle pulse when the final word needed padding.

Behaviour:
- Reset values: s_ready=0, IF_wen=0, IF_din=0, busy=0, done=0, pad_err=0; FSM in IDLE; all counters and registers cleared. Reset mid-frame abandons the frame with no further writes.
- Lane i of IF_din occupies bits [(i+1)*(DATA_WIDTH+2)-1 : i*(DATA_WIDTH+2)].
- Within a lane the layout is {SOR, EOR, data}. SOR=1 on column 0 of a row; EOR=1 on column row_len-1. row_len=1 sets both flags.
- Lane 0 holds the earliest element. Rows pack contiguously, so a word may straddle a row boundary.
- Datapath is two stages: a pack register (lane index 0..PAR_WRITE-1) feeding an output register (out_valid).
- The output register drives IF_din directly (registered; stable while waiting). IF_wen = out_valid && !IF_full. out_valid clears on a write unless refilled in the same cycle.
- Pack hand-off: accepting the element for lane PAR_WRITE-1 moves the complete word into the output register in the same edge.
- out_slot_free = !out_valid || !IF_full.
- FSM states: IDLE, STREAM, PAD, DRAIN.
- IDLE:
  - start with row_len!=0 and row_count!=0: latch both, clear counters, busy=1, go to STREAM.
  - start with either length zero: pulse done, stay IDLE, no writes.
- STREAM:
  - s_ready = (lane_idx != PAR_WRITE-1) || out_slot_free.
  - On accept: advance col (wrap at row_len-1 and increment row); advance lane_idx (wrap to 0 on hand-off).
  - On accepting the final element (last row, last col): if the word completed, go to DRAIN, otherwise go to PAD.
  - Sustained throughput is 1 element per cycle while IF_full=0.
- PAD:
  - s_ready=0.
  - When out_slot_free: fill the remaining lanes with data=0 and flags=0, move the word to the output register, pulse pad_err, go to DRAIN.
- DRAIN:
  - s_ready=0.
  - When out_valid=0 (last word written): pulse done, busy=0, go to IDLE.
- start while busy is ignored. row_len and row_count are not re-sampled mid-frame.
- Counter widths are LEN_BITS; no arithmetic overflow is possible with latched lengths.
- Elements presented while not ready or in IDLE are not consumed. Upstream must hold s_valid and s_data until accepted.

Test Plan:
- PAR_WRITE=2, row_len=3, row_count=2, stream 1..6 with IF_full=0 -> 3 IF_wen pulses, pad_err never pulses, done one cycle after the third write:
  - word0 = lane0 {1,0,1}, lane1 {0,0,2}
  - word1 = lane0 {0,1,3}, lane1 {1,0,4}
  - word2 = lane0 {0,0,5}, lane1 {0,1,6}
- Same frame with IF_full held high 5 cycles after word0 is registered -> no IF_wen during those cycles, IF_din stable, s_ready drops once the pack register is full, all 6 elements written exactly once and in order.
- row_len=3, row_count=1, data 7,8,9 -> word0 = lane0 {1,0,7}, lane1 {0,0,8}; word1 = lane0 {0,1,9}, lane1 {0,0,0}; pad_err pulses once; then done.
- row_len=1, row_count=2, data A,B -> single word with lane0 {1,1,A} and lane1 {1,1,B}.
- start with row_len=0 -> done pulses the next cycle, busy stays 0, no IF_wen. A second start asserted mid-frame is ignored and the frame output is unchanged.
- Assert rst after 2 of 6 elements -> all outputs 0 immediately; a new start then produces a clean frame from lane 0 with SOR on the first element.

Source files
------------

// File: rtl/if_stream_feeder_if.sv
// Handshake bundle for if_stream_feeder: the upstream element stream
// (valid/ready/data) and the IF FIFO write port (wen/din/full).
// The master side is the feeder itself; the slave side is its environment.
interface if_stream_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 2
);
  logic                                s_valid;
  logic [DATA_WIDTH-1:0]               s_data;
  logic                                s_ready;
  logic                                IF_wen;
  logic [PAR_WRITE*(DATA_WIDTH+2)-1:0] IF_din;
  logic                                IF_full;

  modport master (
    input  s_valid,
    input  s_data,
    input  IF_full,
    output s_ready,
    output IF_wen,
    output IF_din
  );

  modport slave (
    output s_valid,
    output s_data,
    output IF_full,
    input  s_ready,
    input  IF_wen,
    input  IF_din
  );
endinterface

// File: rtl/if_stream_feeder.sv
// if_stream_feeder: writer-side front end of the PE input-feature FIFO.
// Serial elements are tagged {SOR, EOR, data} and packed PAR_WRITE per word.
// Stage 0 is the pack register, stage 1 the output register that drives the
// FIFO write port directly. The final word of a frame is zero-padded if short.
module if_stream_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 2,
  parameter int LEN_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_BITS-1:0] row_len,
  input  logic [LEN_BITS-1:0] row_count,
  if_stream_feeder_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                pad_err
);

  localparam int LW     = DATA_WIDTH + 2;
  localparam int WW     = PAR_WRITE * LW;
  localparam int LANE_W = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(PAR_WRITE - 1);
  localparam logic [LANE_W-1:0]   LANE_ONE  = LANE_W'(1);
  localparam logic [LEN_BITS-1:0] LEN_ONE   = LEN_BITS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pad_err_q, pad_err_d;

  logic [LEN_BITS-1:0] len_q, cnt_q, col_q, row_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WW-1:0]       pack_q;
  logic [WW-1:0]       out_q;
  logic                out_vld_q;

  logic                ready;
  logic                slot_free, launch, accept, handoff, pad_fire, load_out;
  logic                last_col, last_row, last_lane, last_elem;
  logic [LW-1:0]       elem;
  logic [WW-1:0]       hand_word;

  assign slot_free = !out_vld_q || !bus.IF_full;
  assign launch    = (state_q == IDLE) && start && (row_len != '0) && (row_count != '0);
  assign last_col  = (col_q == len_q - LEN_ONE);
  assign last_row  = (row_q == cnt_q - LEN_ONE);
  assign last_lane = (lane_q == LAST_LANE);
  assign last_elem = last_col && last_row;
  // ready is only ever high in STREAM, so accept needs no state qualifier
  assign accept    = bus.s_valid && ready;
  assign handoff   = accept && last_lane;
  assign pad_fire  = (state_q == PAD) && slot_free;
  assign load_out  = handoff || pad_fire;
  assign elem      = {(col_q == '0), last_col, bus.s_data};

  // Completed word: pack register with the incoming element in the top lane
  always_comb begin
    hand_word = pack_q;
    hand_word[(PAR_WRITE-1)*LW +: LW] = elem;
  end

  // FSM state and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pad_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pad_err_q <= pad_err_d;
    end
  end

  // FSM next-state: a frame ends in PAD when its last word is short
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = STREAM;
      STREAM:  if (accept && last_elem) state_d = last_lane ? DRAIN : PAD;
      PAD:     if (slot_free) state_d = DRAIN;
      DRAIN:   if (slot_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready, busy/done/pad_err next values
  always_comb begin
    ready     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pad_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (launch) busy_d = 1'b1;
          else        done_d = 1'b1;
        end
      end
      STREAM: ready = !last_lane || slot_free;
      PAD:    pad_err_d = slot_free;
      DRAIN: begin
        // slot_free here means the last word leaves on this edge (or already has)
        if (slot_free) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ready = 1'b0;
    endcase
  end

  // ---- stage 0: pack register and row/column/lane counters ----
  // Pack register is cleared on every hand-off so unfilled lanes are already zero for padding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      cnt_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      lane_q <= '0;
      pack_q <= '0;
    end else if (launch) begin
      len_q  <= row_len;
      cnt_q  <= row_count;
      col_q  <= '0;
      row_q  <= '0;
      lane_q <= '0;
      pack_q <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + LEN_ONE;
      end else begin
        col_q <= col_q + LEN_ONE;
      end
      if (handoff) begin
        lane_q <= '0;
        pack_q <= '0;
      end else begin
        lane_q <= lane_q + LANE_ONE;
        pack_q[lane_q*LW +: LW] <= elem;
      end
    end else if (pad_fire) begin
      lane_q <= '0;
      pack_q <= '0;
    end
  end

  // ---- stage 1: output register driving the FIFO write port ----
  // Holds the word until the FIFO takes it; a refill in the write cycle keeps it valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (load_out) begin
      out_q     <= handoff ? hand_word : pack_q;
      out_vld_q <= 1'b1;
    end else if (out_vld_q && !bus.IF_full) begin
      out_vld_q <= 1'b0;
    end
  end

  assign bus.s_ready = ready;
  assign bus.IF_wen  = out_vld_q && !bus.IF_full;
  assign bus.IF_din  = out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pad_err     = pad_err_q;

endmodule

// File: tb/tb_if_stream_feeder.sv
// Self-checking bench for if_stream_feeder. A frame-level reference model
// tags every element from its position in the frame, pads the tail and
// chunks the result into words; a monitor collects every FIFO write.
module tb_if_stream_feeder;
  localparam int DW = 8;
  localparam int PW = 2;
  localparam int LB = 8;
  localparam int LW = DW + 2;
  localparam int WW = PW * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LB-1:0] row_len, row_count;
  logic          busy, done, pad_err;

  if_stream_feeder_if #(.DATA_WIDTH(DW), .PAR_WRITE(PW)) bus ();

  if_stream_feeder #(.DATA_WIDTH(DW), .PAR_WRITE(PW), .LEN_BITS(LB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_len   (row_len),
    .row_count (row_count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .pad_err   (pad_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // monitor state (written only by the monitor processes)
  int            cyc = 0;
  int            done_cnt = 0;
  int            pad_cnt = 0;
  int            last_wen_cyc = 0;
  int            done_cyc = 0;
  logic [WW-1:0] got_q[$];

  // reference model state
  logic [DW-1:0] dat_q[$];
  logic [WW-1:0] exp_q[$];
  int            exp_pad;
  int            frame_g0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.IF_wen === 1'b1) begin
      got_q.push_back(bus.IF_din);
      last_wen_cyc <= cyc;
    end
    if (pad_err === 1'b1) pad_cnt <= pad_cnt + 1;
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: element k sits in row k/L, column k%L; words are filled lane 0 first
  task automatic build_model(input int L, input int R);
    int            n;
    int            lane;
    logic [WW-1:0] w;
    n = L * R;
    exp_q.delete();
    w = '0;
    lane = 0;
    for (int k = 0; k < n; k++) begin
      w[lane*LW +: LW] = {1'((k % L) == 0), 1'((k % L) == L - 1), dat_q[k]};
      lane++;
      if (lane == PW) begin
        exp_q.push_back(w);
        w = '0;
        lane = 0;
      end
    end
    if (lane != 0) exp_q.push_back(w);
    exp_pad = (lane != 0) ? 1 : 0;
  endtask

  task automatic fill_random(input int n);
    dat_q.delete();
    for (int k = 0; k < n; k++) dat_q.push_back(DW'($urandom));
  endtask

  // Runs one frame from dat_q; optionally holds IF_full for hold_full cycles once
  // the first word is registered, and re-pulses start at loop cycle restart_at.
  task automatic run_frame(input string tag, input int L, input int R, input int valid_pct,
                           input int full_pct, input int hold_full, input int restart_at);
    int            n, idx, k, g0, p0, d0, hold_left;
    logic          vhold, in_win;
    logic [WW-1:0] held;
    n = L * R;
    idx = 0;
    k = 0;
    vhold = 1'b0;
    held = '0;
    build_model(L, R);
    g0 = got_q.size();
    p0 = pad_cnt;
    d0 = done_cnt;
    hold_left = hold_full;
    frame_g0 = g0;
    @(posedge clk); #1;
    start = 1'b1;
    row_len = LB'(L);
    row_count = LB'(R);
    bus.s_valid = 1'b0;
    bus.IF_full = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    row_len = LB'($urandom);
    row_count = LB'($urandom);
    while (done_cnt == d0 && k < 600) begin
      start = (k == restart_at);
      if (!vhold) vhold = (idx < n) && ($urandom_range(99) < valid_pct);
      bus.s_valid = vhold;
      bus.s_data = vhold ? dat_q[idx] : DW'($urandom);
      in_win = (hold_left > 0) && (idx >= PW);
      bus.IF_full = in_win ? 1'b1 : ($urandom_range(99) < full_pct);
      @(negedge clk);
      if (in_win) begin
        if (hold_left == hold_full) held = bus.IF_din;
        else chk({tag, "_hold_din"}, bus.IF_din, held);
        chk({tag, "_hold_wen"}, bus.IF_wen, 0);
        if (hold_left == 1) begin
          chk({tag, "_hold_sready"}, bus.s_ready, 0);
          chk({tag, "_hold_accepted"}, idx, PW + 1);
        end
        hold_left--;
      end
      if (bus.s_valid && bus.s_ready) begin
        idx++;
        vhold = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.IF_full = 1'b0;
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_accepted"}, idx, n);
    chk({tag, "_nwords"}, got_q.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++)
      chk({tag, "_word"}, got_q[g0 + i], exp_q[i]);
    chk({tag, "_pad"}, pad_cnt - p0, exp_pad);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int g0, d0;
    rst = 1'b1;
    start = 1'b0;
    row_len = '0;
    row_count = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.IF_full = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_IF_wen", bus.IF_wen, 0);
    chk("rst_IF_din", bus.IF_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pad_err", pad_err, 0);
    rst = 1'b0;

    // elements offered in IDLE are not consumed
    bus.s_valid = 1'b1;
    bus.s_data = 8'h55;
    @(negedge clk);
    chk("idle_s_ready", bus.s_ready, 0);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;

    // basic 3x2 frame, free-flowing FIFO
    dat_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    run_frame("basic", 3, 2, 100, 0, 0, -1);
    chk("basic_w0", got_q[frame_g0 + 0], {2'b00, 8'd2, 2'b10, 8'd1});
    chk("basic_w1", got_q[frame_g0 + 1], {2'b10, 8'd4, 2'b01, 8'd3});
    chk("basic_w2", got_q[frame_g0 + 2], {2'b01, 8'd6, 2'b00, 8'd5});
    chk("basic_done_timing", done_cyc, last_wen_cyc + 1);

    // same frame with IF_full held for 5 cycles after word0 is registered
    run_frame("stall", 3, 2, 100, 0, 5, -1);
    chk("stall_w1", got_q[frame_g0 + 1], {2'b10, 8'd4, 2'b01, 8'd3});

    // short final word gets padded
    dat_q = '{8'd7, 8'd8, 8'd9};
    run_frame("pad", 3, 1, 100, 0, 0, -1);
    chk("pad_w0", got_q[frame_g0 + 0], {2'b00, 8'd8, 2'b10, 8'd7});
    chk("pad_w1", got_q[frame_g0 + 1], {2'b00, 8'd0, 2'b01, 8'd9});

    // single-element rows carry both flags
    dat_q = '{8'hA, 8'hB};
    run_frame("len1", 1, 2, 100, 0, 0, -1);
    chk("len1_w0", got_q[frame_g0 + 0], {2'b11, 8'hB, 2'b11, 8'hA});

    // zero-length starts
    @(posedge clk); #1;
    g0 = got_q.size();
    d0 = done_cnt;
    start = 1'b1;
    row_len = '0;
    row_count = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zlen_done", done, 1);
    chk("zlen_busy", busy, 0);
    @(posedge clk); #1;
    chk("zlen_done_pulse", done, 0);
    start = 1'b1;
    row_len = 8'd4;
    row_count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zcnt_done", done, 1);
    chk("zcnt_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_no_writes", got_q.size() - g0, 0);
    chk("zero_done_count", done_cnt - d0, 2);

    // second start mid-frame is ignored
    fill_random(6);
    run_frame("restart", 3, 2, 100, 0, 0, 2);

    // reset mid-frame after two elements, word0 stuck behind a full FIFO
    fill_random(6);
    @(posedge clk); #1;
    start = 1'b1;
    row_len = 8'd3;
    row_count = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    bus.IF_full = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = dat_q[0];
    @(posedge clk); #1;
    bus.s_data = dat_q[1];
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    g0 = got_q.size();
    chk("mid_din_before_rst", bus.IF_din, {2'b00, dat_q[1], 2'b10, dat_q[0]});
    rst = 1'b1;
    bus.IF_full = 1'b0;
    #1;
    chk("mid_rst_s_ready", bus.s_ready, 0);
    chk("mid_rst_IF_wen", bus.IF_wen, 0);
    chk("mid_rst_IF_din", bus.IF_din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pad_err", pad_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_writes", got_q.size() - g0, 0);
    fill_random(6);
    run_frame("post_rst", 3, 2, 100, 0, 0, -1);

    // randomized frames with random valid gaps and FIFO back-pressure
    for (int f = 0; f < 6; f++) begin
      int L, R;
      L = $urandom_range(5, 1);
      R = $urandom_range(4, 1);
      fill_random(L * R);
      run_frame("rand", L, R, 70, 35, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
